// File: rtl/tft_pkg.sv
// rtl/tft_pkg.sv - shared TFT panel types and constants
package tft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_LINGER = 2'd2
    } tft_state_t;

    localparam logic DC_COMMAND = 1'b0;
    localparam logic DC_DATA    = 1'b1;

    localparam int SCENE_WIDTH  = 320;
    localparam int SCENE_HEIGHT = 480;

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - SCK half-period tick generator with rise/fall strobes
module spi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt;
    logic       phase;
    logic       tick;

    assign tick = en && (cnt == DIV_LAST);
    assign rise = tick && !phase;
    assign fall = tick && phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 8'd0;
            phase <= 1'b0;
        end else if (clr) begin
            cnt   <= 8'd0;
            phase <= 1'b0;
        end else if (en) begin
            if (tick) begin
                cnt   <= 8'd0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/tft_spi_tx.sv
// rtl/tft_spi_tx.sv - byte-wide TFT command/data transmitter onto 4-wire SPI (mode 0, MSB first)
module tft_spi_tx
    import tft_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int CS_LINGER = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tft_data,
    input  logic       tft_dc,
    input  logic       tft_transmit,
    output logic       busy,
    output logic       overrun,
    output logic       spi_sck,
    output logic       spi_mosi,
    output logic       spi_cs_n,
    output logic       spi_dc
);

    localparam logic [9:0] LINGER_LAST = (CS_LINGER == 0) ? 10'd0 : 10'(CS_LINGER - 1);

    tft_state_t state;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic [9:0] lin_cnt;
    logic       accept;
    logic       sck_rise;
    logic       sck_fall;

    assign accept   = tft_transmit && !busy;
    assign spi_mosi = shreg[7];

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state == ST_SHIFT),
        .clr  (accept),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            overrun  <= 1'b0;
            spi_sck  <= 1'b0;
            spi_cs_n <= 1'b1;
            spi_dc   <= 1'b0;
            shreg    <= 8'd0;
            bit_cnt  <= 3'd0;
            lin_cnt  <= 10'd0;
        end else begin
            if (tft_transmit && busy) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE, ST_LINGER: begin
                    if (accept) begin
                        state    <= ST_SHIFT;
                        busy     <= 1'b1;
                        spi_cs_n <= 1'b0;
                        spi_dc   <= tft_dc;
                        shreg    <= tft_data;
                        spi_sck  <= 1'b0;
                        bit_cnt  <= 3'd0;
                        lin_cnt  <= 10'd0;
                    end else if (state == ST_LINGER) begin
                        // an accept in the timeout cycle takes the branch above, keeping CS low
                        if (lin_cnt == LINGER_LAST) begin
                            state    <= ST_IDLE;
                            spi_cs_n <= 1'b1;
                            lin_cnt  <= 10'd0;
                        end else begin
                            lin_cnt <= lin_cnt + 10'd1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (sck_rise) begin
                        spi_sck <= 1'b1;
                    end else if (sck_fall) begin
                        spi_sck <= 1'b0;
                        if (bit_cnt == 3'd7) begin
                            // last bit leaves MOSI untouched so it holds until the next load
                            busy    <= 1'b0;
                            lin_cnt <= 10'd0;
                            if (CS_LINGER == 0) begin
                                state    <= ST_IDLE;
                                spi_cs_n <= 1'b1;
                            end else begin
                                state <= ST_LINGER;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= {shreg[6:0], 1'b0};
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tft_spi_tx.sv
// tb/tb_tft_spi_tx.sv - self-checking bench for tft_spi_tx
module tb_tft_spi_tx;
    import tft_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] tdata [2];
    logic       tdc   [2];
    logic       ttx   [2];
    logic       busy  [2];
    logic       ovr   [2];
    logic       sck   [2];
    logic       mosi  [2];
    logic       csn   [2];
    logic       dc    [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    tft_spi_tx #(.CLK_DIV(2), .CS_LINGER(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .tft_data(tdata[0]), .tft_dc(tdc[0]),
        .tft_transmit(ttx[0]), .busy(busy[0]), .overrun(ovr[0]), .spi_sck(sck[0]),
        .spi_mosi(mosi[0]), .spi_cs_n(csn[0]), .spi_dc(dc[0])
    );

    tft_spi_tx #(.CLK_DIV(1), .CS_LINGER(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .tft_data(tdata[1]), .tft_dc(tdc[1]),
        .tft_transmit(ttx[1]), .busy(busy[1]), .overrun(ovr[1]), .spi_sck(sck[1]),
        .spi_mosi(mosi[1]), .spi_cs_n(csn[1]), .spi_dc(dc[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dv(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic int ln(input int i);
        return (i == 0) ? 4 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: k = cycles since byte start, idle = cycles since byte end.
    logic       m_in   [2];
    logic       m_cs   [2];
    logic       m_dc   [2];
    logic       m_ovr  [2];
    logic       m_sent [2];
    logic [7:0] m_byte [2];
    int         m_k    [2];
    int         m_idle [2];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_in[i] = 0; m_cs[i] = 1; m_dc[i] = 0; m_ovr[i] = 0; m_sent[i] = 0;
                m_byte[i] = 8'h00; m_k[i] = 0; m_idle[i] = 0;
            end else begin
                if (ttx[i] && m_in[i]) m_ovr[i] = 1;
                if (ttx[i] && !m_in[i]) begin
                    m_in[i] = 1; m_k[i] = 0; m_byte[i] = tdata[i]; m_dc[i] = tdc[i];
                    m_cs[i] = 0; m_sent[i] = 1;
                end else if (m_in[i]) begin
                    m_k[i]++;
                    if (m_k[i] == 16 * dv(i)) begin
                        m_in[i] = 0; m_idle[i] = 0;
                        if (ln(i) == 0) m_cs[i] = 1;
                    end
                end else if (!m_cs[i]) begin
                    m_idle[i]++;
                    if (m_idle[i] == ln(i)) m_cs[i] = 1;
                end
            end
        end
    end

    logic        p_sck [2] = '{0, 0};
    logic        p_bsy [2] = '{0, 0};
    logic        p_csn [2] = '{1, 1};
    int          rises [2] = '{0, 0};
    int          cs_rises [2] = '{0, 0};
    int          b_rise [2] = '{0, 0};
    int          b_fall [2] = '{0, 0};
    int          cs_rise [2] = '{0, 0};
    logic [31:0] bits  [2] = '{0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [5:0] expv;
            logic       e_sck;
            logic       e_mosi;
            e_sck  = m_in[i] ? logic'((m_k[i] / dv(i)) % 2) : 1'b0;
            e_mosi = m_in[i] ? m_byte[i][7 - m_k[i] / (2 * dv(i))]
                             : (m_sent[i] ? m_byte[i][0] : 1'b0);
            expv = {m_in[i], m_ovr[i], e_sck, e_mosi, m_cs[i], m_dc[i]};
            chk($sformatf("cycle%0d_dut%0d{busy,ovr,sck,mosi,csn,dc}", cyc, i),
                {26'd0, busy[i], ovr[i], sck[i], mosi[i], csn[i], dc[i]}, {26'd0, expv});
            if (rst_n) begin
                if (!p_sck[i] && sck[i]) begin
                    rises[i]++;
                    bits[i] = {bits[i][30:0], mosi[i]};
                end
                if (!p_bsy[i] && busy[i]) b_rise[i] = cyc;
                if (p_bsy[i] && !busy[i]) b_fall[i] = cyc;
                if (!p_csn[i] && csn[i]) begin
                    cs_rise[i] = cyc;
                    cs_rises[i]++;
                end
            end
            p_sck[i] = sck[i]; p_bsy[i] = busy[i]; p_csn[i] = csn[i];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log(input int i);
        rises[i] = 0; cs_rises[i] = 0; bits[i] = 0;
    endtask

    // Raise tft_transmit for one cycle starting now; t is that request cycle.
    task automatic send(input int i, input logic [7:0] d, input logic c, output int t);
        tdata[i] = d; tdc[i] = c; ttx[i] = 1'b1; t = cyc;
        step();
        ttx[i] = 1'b0;
    endtask

    initial begin
        int t1;
        int t2;
        int n;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tdata[i] = 8'h00; tdc[i] = 1'b0; ttx[i] = 1'b0;
        end
        repeat (3) step();
        rst_n = 1'b1;
        chk("reset_csn0", 32'(csn[0]), 32'd1);
        chk("reset_busy0", 32'(busy[0]), 32'd0);
        repeat (10) step();
        chk("idle_csn0", 32'(csn[0]), 32'd1);

        // single command byte
        clear_log(0);
        send(0, 8'hA5, DC_COMMAND, t1);
        repeat (50) step();
        chk("a5_bits", bits[0], 32'h0000_00A5);
        chk("a5_rises", 32'(rises[0]), 32'd8);
        chk("a5_busy_rise", 32'(b_rise[0] - t1), 32'd1);
        chk("a5_busy_fall", 32'(b_fall[0] - t1), 32'd33);
        chk("a5_cs_rise", 32'(cs_rise[0] - t1), 32'd37);

        // back-to-back data bytes
        clear_log(0);
        send(0, 8'hFE, DC_DATA, t1);
        n = 0;
        while (busy[0] !== 1'b0 && n < 100) begin
            step();
            n++;
        end
        chk("b2b_wait_bound", 32'(n < 100), 32'd1);
        send(0, 8'h10, DC_DATA, t2);
        repeat (60) step();
        chk("b2b_spacing", 32'(t2 - t1), 32'd33);
        chk("b2b_bits", bits[0], 32'h0000_FE10);
        chk("b2b_rises", 32'(rises[0]), 32'd16);
        chk("b2b_cs_rises", 32'(cs_rises[0]), 32'd1);

        // overrun
        clear_log(0);
        send(0, 8'h55, DC_DATA, t1);
        repeat (4) step();
        send(0, 8'h00, DC_COMMAND, t2);
        chk("ovr_set", 32'(ovr[0]), 32'd1);
        repeat (60) step();
        chk("ovr_bits", bits[0], 32'h0000_0055);
        chk("ovr_rises", 32'(rises[0]), 32'd8);
        chk("ovr_sticky", 32'(ovr[0]), 32'd1);

        // accept on the 4th linger cycle beats the timeout
        clear_log(0);
        send(0, 8'h3C, DC_COMMAND, t1);
        while (cyc < t1 + 36) step();
        send(0, 8'hC3, DC_DATA, t2);
        repeat (60) step();
        chk("race_spacing", 32'(t2 - t1), 32'd36);
        chk("race_bits", bits[0], 32'h0000_3CC3);
        chk("race_cs_rises", 32'(cs_rises[0]), 32'd1);
        chk("race_cs_rise", 32'(cs_rise[0] - t2), 32'd37);

        // CLK_DIV=1, CS_LINGER=0
        clear_log(1);
        send(1, 8'h2C, DC_COMMAND, t1);
        repeat (30) step();
        chk("d1_busy_rise", 32'(b_rise[1] - t1), 32'd1);
        chk("d1_busy_len", 32'(b_fall[1] - b_rise[1]), 32'd16);
        chk("d1_cs_with_busy", 32'(cs_rise[1] - b_fall[1]), 32'd0);
        chk("d1_bits", bits[1], 32'h0000_002C);
        chk("d1_rises", 32'(rises[1]), 32'd8);

        // reset mid-byte on both instances
        send(0, 8'h81, DC_DATA, t1);
        send(1, 8'h81, DC_DATA, t2);
        repeat (3) step();
        chk("pre_reset_busy0", 32'(busy[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset0", {26'd0, busy[0], ovr[0], sck[0], mosi[0], csn[0], dc[0]}, 32'h02);
        chk("async_reset1", {26'd0, busy[1], ovr[1], sck[1], mosi[1], csn[1], dc[1]}, 32'h02);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (10) step();
        chk("post_reset_csn0", 32'(csn[0]), 32'd1);
        chk("post_reset_csn1", 32'(csn[1]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
